// File: rtl/response_collector.sv
// rtl/response_collector.sv - five-lane memory response return path with per-port FIFOs
module response_collector #(
    parameter int DATA_W     = 16,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            lane_valid,
    input  logic [9:0]            lane_port_id,
    input  logic [5*TAG_W-1:0]    lane_req_tag,
    input  logic [4:0]            lane_wen,
    input  logic [5*DATA_W-1:0]   lane_dataout,
    output logic [2:0]            port_rsp_valid,
    input  logic [2:0]            port_rsp_ready,
    output logic [3*DATA_W-1:0]   port_rsp_data,
    output logic [3*TAG_W-1:0]    port_rsp_tag,
    output logic [2:0]            port_rsp_wen,
    output logic [2:0]            port_stall,
    input  logic                  err_clr,
    output logic                  err_bad_id,
    output logic                  err_collision,
    output logic                  err_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + TAG_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH - 2);

    logic [4:0]          s1_valid_q;
    logic [9:0]          s1_id_q;
    logic [5*TAG_W-1:0]  s1_tag_q;
    logic [4:0]          s1_wen_q;
    logic [5*DATA_W-1:0] s1_data_q;

    logic [4:0]       hit [3];
    logic [2:0]       push;
    logic [ENT_W-1:0] push_entry [3];
    logic             bad_set, coll_set, ovf_set;

    logic [ENT_W-1:0] mem_q [3][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [3], wr_ptr_d [3];
    logic [PTR_W-1:0] rd_ptr_q [3], rd_ptr_d [3];
    logic [CNT_W-1:0] cnt_q [3], cnt_d [3];
    logic [2:0]       pop, do_push, stall_q;
    logic             err_bad_id_q, err_collision_q, err_overflow_q;
    logic             err_bad_id_d, err_collision_d, err_overflow_d;

    // Stage 1: only the valids need reset; payload is captured every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= '0;
        end else begin
            s1_valid_q <= lane_valid;
        end
    end

    // Stage 1 payload register
    always_ff @(posedge clk) begin
        s1_id_q   <= lane_port_id;
        s1_tag_q  <= lane_req_tag;
        s1_wen_q  <= lane_wen;
        s1_data_q <= lane_dataout;
    end

    // Stage 2 routing: lowest lane index wins per port; detect bad ids and collisions
    always_comb begin
        bad_set  = 1'b0;
        coll_set = 1'b0;
        for (int l = 0; l < 5; l++) begin
            if (s1_valid_q[l] && (s1_id_q[2*l +: 2] == 2'd0)) bad_set = 1'b1;
        end
        for (int p = 0; p < 3; p++) begin
            hit[p]        = '0;
            push_entry[p] = '0;
            for (int l = 0; l < 5; l++) begin
                hit[p][l] = s1_valid_q[l] && (s1_id_q[2*l +: 2] == 2'(p + 1));
            end
            push[p] = |hit[p];
            if ((hit[p] & (hit[p] - 5'd1)) != 5'd0) coll_set = 1'b1;
            for (int l = 4; l >= 0; l--) begin
                if (hit[p][l]) begin
                    push_entry[p] = {s1_wen_q[l], s1_tag_q[l*TAG_W +: TAG_W],
                                     s1_wen_q[l] ? {DATA_W{1'b0}} : s1_data_q[l*DATA_W +: DATA_W]};
                end
            end
        end
    end

    // FIFO control and head presentation; a full FIFO still accepts a push when popping
    always_comb begin
        ovf_set       = 1'b0;
        port_rsp_data = '0;
        port_rsp_tag  = '0;
        port_rsp_wen  = '0;
        for (int p = 0; p < 3; p++) begin
            port_rsp_valid[p] = (cnt_q[p] != '0);
            pop[p]            = port_rsp_valid[p] && port_rsp_ready[p];
            do_push[p]        = push[p] && ((cnt_q[p] != FULL_CNT) || pop[p]);
            if (push[p] && (cnt_q[p] == FULL_CNT) && !pop[p]) ovf_set = 1'b1;
            wr_ptr_d[p] = do_push[p] ? wr_ptr_q[p] + PTR_W'(1) : wr_ptr_q[p];
            rd_ptr_d[p] = pop[p] ? rd_ptr_q[p] + PTR_W'(1) : rd_ptr_q[p];
            cnt_d[p]    = cnt_q[p];
            if (do_push[p] && !pop[p]) cnt_d[p] = cnt_q[p] + CNT_W'(1);
            if (!do_push[p] && pop[p]) cnt_d[p] = cnt_q[p] - CNT_W'(1);
            if (port_rsp_valid[p]) begin
                port_rsp_data[p*DATA_W +: DATA_W] = mem_q[p][rd_ptr_q[p]][DATA_W-1:0];
                port_rsp_tag[p*TAG_W +: TAG_W]    = mem_q[p][rd_ptr_q[p]][DATA_W +: TAG_W];
                port_rsp_wen[p]                   = mem_q[p][rd_ptr_q[p]][ENT_W-1];
            end
        end
        err_bad_id_d    = bad_set  | (err_bad_id_q    & ~err_clr);
        err_collision_d = coll_set | (err_collision_q & ~err_clr);
        err_overflow_d  = ovf_set  | (err_overflow_q  & ~err_clr);
    end

    // FIFO storage write; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (do_push[p]) mem_q[p][wr_ptr_q[p]] <= push_entry[p];
        end
    end

    // FIFO pointers, counts, stall and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
            stall_q         <= '0;
            err_bad_id_q    <= 1'b0;
            err_collision_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                cnt_q[p]    <= cnt_d[p];
                stall_q[p]  <= (cnt_q[p] >= STALL_CNT);
            end
            err_bad_id_q    <= err_bad_id_d;
            err_collision_q <= err_collision_d;
            err_overflow_q  <= err_overflow_d;
        end
    end

    assign port_stall    = stall_q;
    assign err_bad_id    = err_bad_id_q;
    assign err_collision = err_collision_q;
    assign err_overflow  = err_overflow_q;
endmodule

// File: tb/tb_response_collector.sv
// tb/tb_response_collector.sv - self-checking bench for response_collector
module tb_response_collector;
    localparam int DW = 16;
    localparam int TW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    lane_valid;
    logic [9:0]    lane_port_id;
    logic [5*TW-1:0] lane_req_tag;
    logic [4:0]    lane_wen;
    logic [5*DW-1:0] lane_dataout;
    logic [2:0]    port_rsp_valid;
    logic [2:0]    port_rsp_ready;
    logic [3*DW-1:0] port_rsp_data;
    logic [3*TW-1:0] port_rsp_tag;
    logic [2:0]    port_rsp_wen;
    logic [2:0]    port_stall;
    logic          err_clr;
    logic          err_bad_id, err_collision, err_overflow;

    int tests = 0;
    int fails = 0;

    // Reference model: stage-1 copy of lane inputs, one queue per port, flags
    logic [18:0]   mq [3][$];
    logic [2:0]    m_stall;
    logic          m_bad, m_coll, m_ovf;
    logic [4:0]    m_v;
    logic [9:0]    m_id;
    logic [9:0]    m_tag;
    logic [4:0]    m_wen;
    logic [79:0]   m_data;

    response_collector #(.DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .lane_valid(lane_valid), .lane_port_id(lane_port_id), .lane_req_tag(lane_req_tag),
        .lane_wen(lane_wen), .lane_dataout(lane_dataout),
        .port_rsp_valid(port_rsp_valid), .port_rsp_ready(port_rsp_ready),
        .port_rsp_data(port_rsp_data), .port_rsp_tag(port_rsp_tag), .port_rsp_wen(port_rsp_wen),
        .port_stall(port_stall), .err_clr(err_clr),
        .err_bad_id(err_bad_id), .err_collision(err_collision), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic bad, coll, ovf;
        int n, win;
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) mq[p].delete();
            m_stall = '0; m_bad = 0; m_coll = 0; m_ovf = 0; m_v = '0;
        end else begin
            bad = 0; coll = 0; ovf = 0;
            for (int l = 0; l < 5; l++) if (m_v[l] && m_id[2*l +: 2] == 2'd0) bad = 1;
            for (int p = 0; p < 3; p++) begin
                m_stall[p] = (mq[p].size() >= DEPTH - 2);
                if (mq[p].size() > 0 && port_rsp_ready[p]) void'(mq[p].pop_front());
                n = 0; win = -1;
                for (int l = 0; l < 5; l++) begin
                    if (m_v[l] && m_id[2*l +: 2] == 2'(p + 1)) begin
                        n++;
                        if (win < 0) win = l;
                    end
                end
                if (n > 1) coll = 1;
                if (n > 0) begin
                    if (mq[p].size() < DEPTH)
                        mq[p].push_back({m_wen[win], m_tag[win*2 +: 2],
                                         m_wen[win] ? 16'h0000 : m_data[win*16 +: 16]});
                    else
                        ovf = 1;
                end
            end
            m_bad  = bad  | (m_bad  & ~err_clr);
            m_coll = coll | (m_coll & ~err_clr);
            m_ovf  = ovf  | (m_ovf  & ~err_clr);
            m_v = lane_valid; m_id = lane_port_id; m_tag = lane_req_tag;
            m_wen = lane_wen; m_data = lane_dataout;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        lane_valid = '0; lane_port_id = '0; lane_req_tag = '0; lane_wen = '0; lane_dataout = '0;
    endtask

    task automatic set_lane(input int l, input logic [1:0] id, input logic [1:0] tag,
                            input logic wen, input logic [15:0] data);
        lane_valid[l] = 1'b1;
        lane_port_id[2*l +: 2] = id;
        lane_req_tag[2*l +: 2] = tag;
        lane_wen[l] = wen;
        lane_dataout[16*l +: 16] = data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; err_clr = 1'b0; port_rsp_ready = '0;
        clear_lanes();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({port_rsp_valid, port_stall, port_rsp_wen} !== 9'h0) begin
            fails++; $display("FAIL reset_valid_stall_wen: got %h expected 000", {port_rsp_valid, port_stall, port_rsp_wen});
        end
        tests++;
        if ({port_rsp_data, port_rsp_tag} !== '0) begin
            fails++; $display("FAIL reset_data_tag: got %h expected 0", {port_rsp_data, port_rsp_tag});
        end
        tests++;
        if ({err_bad_id, err_collision, err_overflow} !== 3'b000) begin
            fails++; $display("FAIL reset_errors: got %b expected 000", {err_bad_id, err_collision, err_overflow});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        port_rsp_ready = 3'b111;
        set_lane(3, 2'd2, 2'd3, 1'b0, 16'hBEEF);
        tick();
        clear_lanes();
        tests++;
        if (port_rsp_valid !== 3'b000) begin
            fails++; $display("FAIL single_early_valid: got %b expected 000", port_rsp_valid);
        end
        tick();
        tests++;
        if (port_rsp_valid !== 3'b010 || port_rsp_data[31:16] !== 16'hBEEF ||
            port_rsp_tag[3:2] !== 2'd3 || port_rsp_wen[1] !== 1'b0) begin
            fails++; $display("FAIL single_head: got v=%b d=%h t=%h w=%b expected v=010 d=beef t=3 w=0",
                              port_rsp_valid, port_rsp_data[31:16], port_rsp_tag[3:2], port_rsp_wen[1]);
        end
        tick();
        tests++;
        if (port_rsp_valid !== 3'b000) begin
            fails++; $display("FAIL single_popped: got %b expected 000", port_rsp_valid);
        end
    endtask

    task automatic test_fanin();
        do_reset();
        port_rsp_ready = 3'b111;
        set_lane(0, 2'd1, 2'd1, 1'b1, 16'h1234);
        set_lane(3, 2'd2, 2'd2, 1'b0, 16'hAAAA);
        set_lane(4, 2'd3, 2'd0, 1'b0, 16'h5555);
        tick();
        clear_lanes();
        tick();
        tests++;
        if (port_rsp_valid !== 3'b111 || port_rsp_data !== {16'h5555, 16'hAAAA, 16'h0000} ||
            port_rsp_wen !== 3'b001 || port_rsp_tag !== {2'd0, 2'd2, 2'd1}) begin
            fails++; $display("FAIL fanin_heads: got v=%b d=%h w=%b t=%h expected v=111 d=5555aaaa0000 w=001 t=09",
                              port_rsp_valid, port_rsp_data, port_rsp_wen, port_rsp_tag);
        end
        tests++;
        if ({err_bad_id, err_collision, err_overflow} !== 3'b000) begin
            fails++; $display("FAIL fanin_errors: got %b expected 000", {err_bad_id, err_collision, err_overflow});
        end
    endtask

    task automatic test_collision();
        do_reset();
        set_lane(0, 2'd3, 2'd0, 1'b0, 16'h0001);
        set_lane(1, 2'd3, 2'd1, 1'b0, 16'h0002);
        tick();
        clear_lanes();
        tick();
        tests++;
        if (port_rsp_valid !== 3'b100 || port_rsp_data[47:32] !== 16'h0001 || err_collision !== 1'b1) begin
            fails++; $display("FAIL collision_first: got v=%b d=%h e=%b expected v=100 d=0001 e=1",
                              port_rsp_valid, port_rsp_data[47:32], err_collision);
        end
        port_rsp_ready = 3'b100;
        tick();
        tests++;
        if (port_rsp_valid !== 3'b000 || err_collision !== 1'b1) begin
            fails++; $display("FAIL collision_single_entry_sticky: got v=%b e=%b expected v=000 e=1",
                              port_rsp_valid, err_collision);
        end
        set_lane(2, 2'd1, 2'd0, 1'b0, 16'h0003);
        set_lane(4, 2'd1, 2'd0, 1'b0, 16'h0004);
        tick();
        clear_lanes();
        err_clr = 1'b1;
        tick();
        tests++;
        if (err_collision !== 1'b1) begin
            fails++; $display("FAIL collision_set_beats_clear: got %b expected 1", err_collision);
        end
        tick();
        err_clr = 1'b0;
        tests++;
        if (err_collision !== 1'b0) begin
            fails++; $display("FAIL collision_cleared: got %b expected 0", err_collision);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d [6];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_lanes();
            d[i] = 16'($urandom);
            set_lane(3, 2'd1, 2'(i % 4), 1'b0, d[i]);
            tick();
            if (i == 2) begin
                tests++;
                if (port_stall[0] !== 1'b0) begin
                    fails++; $display("FAIL ovf_stall_low_at_count1: got %b expected 0", port_stall[0]);
                end
            end
            if (i == 3) begin
                tests++;
                if (port_stall[0] !== 1'b1) begin
                    fails++; $display("FAIL ovf_stall_high_at_count2: got %b expected 1", port_stall[0]);
                end
            end
            if (i == 4) begin
                tests++;
                if (err_overflow !== 1'b0) begin
                    fails++; $display("FAIL ovf_early_at_full: got %b expected 0", err_overflow);
                end
            end
            if (i == 5) begin
                tests++;
                if (err_overflow !== 1'b1) begin
                    fails++; $display("FAIL ovf_flag: got %b expected 1", err_overflow);
                end
            end
        end
        clear_lanes();
        tick();
        port_rsp_ready = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (port_rsp_valid[0] !== 1'b1 || port_rsp_tag[1:0] !== 2'(i) || port_rsp_data[15:0] !== d[i]) begin
                fails++; $display("FAIL ovf_drain_%0d: got v=%b t=%h d=%h expected v=1 t=%h d=%h",
                                  i, port_rsp_valid[0], port_rsp_tag[1:0], port_rsp_data[15:0], 2'(i), d[i]);
            end
            tick();
        end
        tests++;
        if (port_rsp_valid[0] !== 1'b0 || err_overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_drained_empty: got v=%b e=%b expected v=0 e=1", port_rsp_valid[0], err_overflow);
        end
    endtask

    task automatic test_push_pop_full();
        logic [15:0] d [5];
        do_reset();
        for (int i = 0; i < 5; i++) d[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            clear_lanes();
            set_lane(4, 2'd1, 2'(i), 1'b0, d[i]);
            tick();
        end
        clear_lanes();
        tick();
        set_lane(4, 2'd1, 2'd0, 1'b0, d[4]);
        tick();
        clear_lanes();
        port_rsp_ready = 3'b001;
        tick();
        tests++;
        if (err_overflow !== 1'b0 || port_stall[0] !== 1'b1) begin
            fails++; $display("FAIL pp_full_flags: got ovf=%b stall=%b expected ovf=0 stall=1", err_overflow, port_stall[0]);
        end
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (port_rsp_valid[0] !== 1'b1 || port_rsp_data[15:0] !== d[i]) begin
                fails++; $display("FAIL pp_order_%0d: got v=%b d=%h expected v=1 d=%h",
                                  i, port_rsp_valid[0], port_rsp_data[15:0], d[i]);
            end
            tick();
        end
        tests++;
        if (port_rsp_valid[0] !== 1'b0) begin
            fails++; $display("FAIL pp_empty_after_four: got %b expected 0", port_rsp_valid[0]);
        end
    endtask

    task automatic test_bad_id_reset();
        do_reset();
        set_lane(2, 2'd0, 2'd1, 1'b0, 16'h7777);
        tick();
        clear_lanes();
        tick();
        tests++;
        if (err_bad_id !== 1'b1 || port_rsp_valid !== 3'b000) begin
            fails++; $display("FAIL bad_id: got e=%b v=%b expected e=1 v=000", err_bad_id, port_rsp_valid);
        end
        set_lane(1, 2'd2, 2'd1, 1'b0, 16'h1111);
        tick();
        clear_lanes();
        set_lane(1, 2'd2, 2'd2, 1'b0, 16'h2222);
        tick();
        clear_lanes();
        tick();
        tick();
        tests++;
        if (port_rsp_valid !== 3'b010 || port_stall !== 3'b010) begin
            fails++; $display("FAIL pre_reset_fill: got v=%b s=%b expected v=010 s=010", port_rsp_valid, port_stall);
        end
        set_lane(0, 2'd1, 2'd3, 1'b0, 16'h9999);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_lanes();
        tests++;
        if (port_rsp_valid !== 3'b000 || port_stall !== 3'b000 || port_rsp_data !== '0 ||
            {err_bad_id, err_collision, err_overflow} !== 3'b000) begin
            fails++; $display("FAIL mid_reset: got v=%b s=%b d=%h e=%b expected all 0",
                              port_rsp_valid, port_stall, port_rsp_data, {err_bad_id, err_collision, err_overflow});
        end
        tick();
        tests++;
        if (port_rsp_valid !== 3'b000) begin
            fails++; $display("FAIL inflight_discarded: got %b expected 000", port_rsp_valid);
        end
    endtask

    task automatic test_random();
        logic [18:0] exp_e, got_e;
        int bad_cycles;
        do_reset();
        bad_cycles = 0;
        for (int c = 0; c < 400; c++) begin
            clear_lanes();
            for (int l = 0; l < 5; l++) begin
                if ($urandom_range(0, 1) == 1)
                    set_lane(l, ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
                             2'($urandom), 1'($urandom), 16'($urandom));
            end
            port_rsp_ready = 3'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
            for (int p = 0; p < 3; p++) begin
                tests++;
                if (port_rsp_valid[p] !== (mq[p].size() != 0)) begin
                    fails++; $display("FAIL rand_valid c%0d p%0d: got %b expected %0d", c, p + 1,
                                      port_rsp_valid[p], mq[p].size() != 0);
                end else if (mq[p].size() != 0) begin
                    exp_e = mq[p][0];
                    got_e = {port_rsp_wen[p], port_rsp_tag[2*p +: 2], port_rsp_data[16*p +: 16]};
                    tests++;
                    if (got_e !== exp_e) begin
                        fails++; $display("FAIL rand_head c%0d p%0d: got %h expected %h", c, p + 1, got_e, exp_e);
                    end
                end
            end
            tests++;
            if (port_stall !== m_stall || {err_bad_id, err_collision, err_overflow} !== {m_bad, m_coll, m_ovf}) begin
                fails++; $display("FAIL rand_stall_err c%0d: got s=%b e=%b expected s=%b e=%b", c, port_stall,
                                  {err_bad_id, err_collision, err_overflow}, m_stall, {m_bad, m_coll, m_ovf});
            end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fanin();
        test_collision();
        test_overflow();
        test_push_pop_full();
        test_bad_id_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/response_collector.md
Name: response_collector

Overview:
- Return path of the triple-ported memory: the counterpart to the request steerer.
- Collects responses from the five memory lanes (rw1, rw2, rw3, r1, r2), each tagged with originating port_id and req_tag.
- Routes each response back to port 1, 2 or 3 through a per-port response FIFO with valid/ready handshake toward the port consumer.
- Flags protocol errors: bad port_id, lane collision, FIFO overflow.

Parameters:
- DATA_W, 16, response data width per lane/port.
- TAG_W, 2, request tag width.
- FIFO_DEPTH, 4, entries per port FIFO; power of two, >= 4.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- lane_valid  in  5  per-lane response valid; bit0=rw1, 1=rw2, 2=rw3, 3=r1, 4=r2.
- lane_port_id  in  10  2 bits per lane, same lane order; 2'd1/2/3 = port1/2/3, 2'd0 = unused lane.
- lane_req_tag  in  5*TAG_W  tag per lane.
- lane_wen  in  5  1 = write acknowledgement, 0 = read data.
- lane_dataout  in  5*DATA_W  read data per lane; don't-care when lane_wen=1.
- port_rsp_valid  out  3  bit p-1 = port p has a response at FIFO head.
- port_rsp_ready  in  3  port consumer accepts head.
- port_rsp_data  out  3*DATA_W  head data per port; forced 0 for write acks.
- port_rsp_tag  out  3*TAG_W  head tag per port.
- port_rsp_wen  out  3  head is write ack.
- port_stall  out  3  advisory backpressure per port.
- err_clr  in  1  clears sticky error flags.
- err_bad_id  out  1  sticky.
- err_collision  out  1  sticky.
- err_overflow  out  1  sticky.

Behaviour:
- Reset (rst_n=0 at a rising edge): input stage valids cleared; all FIFO pointers and counts 0; all error flags 0. After reset: port_rsp_valid=0, port_stall=0, data/tag/wen outputs 0.
- Stage 1 (input register): lane_valid/port_id/req_tag/wen/dataout registered every cycle unconditionally. No lane backpressure.
- Stage 2 (route + push), per port p:
  - Candidate lanes: registered valid=1 and port_id=p.
  - Lowest lane index wins and is pushed.
  - If more than one candidate: extras dropped; err_collision set.
- Registered valid lane with port_id=0: dropped; err_bad_id set.
- Latency: lane response sampled at edge E0, pushed at E1; port_rsp_valid high in the cycle after E1 when the FIFO was empty. Minimum 2 cycles.
- FIFO entries: {wen, tag, data}; data stored as 0 when wen=1.
- Outputs: head shown combinationally from storage; port_rsp_valid[p] = (count[p] != 0).
- Pop when port_rsp_valid & port_rsp_ready. Ready while not valid has no effect.
- Simultaneous push+pop: count unchanged. Allowed when full; push and pop both succeed.
- Push when full with no pop: entry dropped, count stays FIFO_DEPTH, err_overflow set.
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- port_stall[p] = (count[p] >= FIFO_DEPTH-2), registered, one-cycle lag from count. Covers the two-stage in-flight window.
- Error flags:
  - Set on the event edge.
  - err_clr=1 clears them at the next edge.
  - If set and clear coincide, set wins.
- Reset mid-operation: all FIFO contents discarded, in-flight stage-1 data discarded, outputs return to reset values the following cycle.

Test Plan:
- Reset, single read: lane r1 valid, port_id=2, tag=2'd3, data=16'hBEEF, ready=1 → port_rsp_valid[1]=1 exactly 2 cycles later with data BEEF, tag 3, wen 0; popped that cycle; valid drops next cycle.
- Full fan-in, no collision: rw1→port1 write ack (dataout=16'h1234), r1→port2 data 16'hAAAA, r2→port3 data 16'h5555 in one cycle → all three ports valid together; port1 data=0, wen=1.
- Collision: rw1 and rw2 both port_id=3 (data 16'h0001, 16'h0002) → port3 receives only 16'h0001; err_collision=1 and stays 1 until err_clr pulse.
- Backpressure/overflow: port1 ready=0, six consecutive responses tags 0,1,2,3,0,1:
  - port_stall[0] rises once count reaches 2.
  - Count saturates at 4; err_overflow=1.
  - Releasing ready drains tags 0,1,2,3 in order.
- Full with push+pop same cycle: FIFO full, ready=1 while a new response arrives → count stays 4, no err_overflow, order preserved.
- Bad id and mid-run reset: valid lane with port_id=0 → err_bad_id=1, no port valid. Then rst_n=0 for one edge with FIFO entries present → all valid, stall and error outputs 0.
